sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Upstream neighbour of the SHA-256 compression round stage.
- Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream.
- Expands the block into the 64-word schedule W_0..W_63.
- Presents each W_t with its round constant K_t and round index t to the round stage over a valid/ready handshake, one word per accepted transfer.

Parameters:
none; SHA-256 is fixed at 16 input words, 64 output words and a 32-bit datapath.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
word_i  input  32  message word M_j, j = 0..15 in arrival order
word_valid  input  1  word_i valid
word_ready  output  1  block can accept a word; high only in LOAD
w_o  output  32  schedule word W_t (to round W_t)
k_o  output  32  round constant K_t (to round K_t)
t_o  output  6  round index t, 0..63
last_o  output  1  high when t_o = 63 and out_valid = 1
out_valid  output  1  w_o/k_o/t_o valid
out_ready  input  1  round stage accepts current word

Behaviour:
- Reset (async, rst_n low): state = LOAD, load count = 0, t = 0, out_valid = 0, last_o = 0, w_o = 0, t_o = 0, window cleared. word_ready = 1 once rst_n is released.
- Storage: 16 x 32-bit window win[0..15], 4-bit load counter, 6-bit round counter t.
- Outputs w_o, t_o, out_valid and last_o come from registers. k_o is a 64-entry constant ROM (FIPS 180-4 K values) indexed by the registered t. There is no combinational path from out_ready to any output.
- State LOAD:
  - word_ready = 1, out_valid = 0.
  - On word_valid & word_ready: win[cnt] <= word_i, cnt++.
  - On acceptance of the 16th word (cnt = 15): go to RUN, t <= 0, out_valid <= 1.
  - No W output is produced during LOAD; latency from the 16th word handshake to the first out_valid is 1 cycle.
- State RUN:
  - word_ready = 0.
  - w_o = win[0], t_o = t, last_o = (t = 63).
  - On out_valid & out_ready:
    - Shift the window: win[i] <= win[i+1] for i = 0..14.
    - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32.
    - t++.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - For t < 16, w_o is the raw message word M_t; for t >= 16, w_o is the expanded word. Expansion continues harmlessly past t = 48; those values are never emitted.
  - When out_valid = 1 and out_ready = 0: w_o, k_o, t_o and last_o hold stable, and the window and t do not change.
  - When t = 63 is accepted: out_valid <= 0, last_o <= 0, cnt <= 0, state <= LOAD. word_ready is high the next cycle.
- Throughput: one W per cycle while out_ready is held high. A block takes 16 load cycles + 64 run cycles, with no overlap between blocks.
- Words presented on word_i during RUN are ignored (word_ready = 0). No input is lost, because the producer must hold word_valid until a handshake.
- Reset mid-operation returns immediately to the reset state. Any partial block or schedule is discarded.
- All additions wrap modulo 2^32 with no carry out.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN at t = 20 -> out_valid = 0 and t_o = 0 immediately; after release word_ready = 1 and no stale W appears.
- "abc" block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), out_ready held 1:
  - out_valid is first seen 1 cycle after the 16th handshake.
  - W0 = 0x61626380, k_o = 0x428a2f98, t_o = 0.
  - W16 = 0x61626380, W17 = 0x000f0000.
  - At t = 63: k_o = 0xc67178f2 and last_o = 1.
  - 64 transfers complete in 64 consecutive cycles.
- Backpressure: hold out_ready = 0 for 5 cycles at t = 17 -> w_o = 0x000f0000 and t_o = 17 stay stable throughout; the sequence resumes unchanged when out_ready returns to 1.
- Gapped input: word_valid toggles 1/0 during load -> exactly 16 words captured in order; words offered during RUN are not accepted (word_ready = 0).
- Back-to-back blocks: second block offered while the first block's t = 63 is pending -> its first word is accepted only in the cycle after the last handshake, and the second schedule starts at t = 0 with K0.
- Random blocks: compare all 64 W_t values against a software model for 100 random blocks -> zero mismatches.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams W_t with K_t and t
// to the round stage, one word per accepted transfer.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [31:0] w_o,
    output logic [31:0] k_o,
    output logic [5:0]  t_o,
    output logic        last_o,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  t_q, t_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        vld_d   = vld_q;
        last_d  = last_q;
        win_d   = win_q;
        case (state_q)
            LOAD: begin
                if (word_valid) begin
                    win_d[cnt_q] = word_i;
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = RUN;
                        t_d     = 6'd0;
                        vld_d   = 1'b1;
                        last_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (vld_q && out_ready) begin
                    // win[0] is W_t; the new tail is W_{t+16}
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
                    win_d[15] = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
                    t_d    = t_q + 6'd1;
                    last_d = (t_q == 6'd62);
                    if (t_q == 6'd63) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 4'd0;
            t_q     <= 6'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    assign word_ready = (state_q == LOAD);
    assign w_o        = win_q[0];
    assign k_o        = K_ROM[t_q];
    assign t_o        = t_q;
    assign last_o     = last_q;
    assign out_valid  = vld_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block, backpressure, gapped load,
// back-to-back blocks, mid-run reset and random blocks against a schedule model.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_i;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] w_o;
    logic [31:0] k_o;
    logic [5:0]  t_o;
    logic        last_o;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg  [16];
    logic [31:0] msgb [16];
    logic [31:0] ws   [64];
    logic [31:0] cap_w[64];
    logic [31:0] cap_k[64];
    logic        cap_last63;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_i     (word_i),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .w_o        (w_o),
        .k_o        (k_o),
        .t_o        (t_o),
        .last_o     (last_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model();
        for (int t = 0; t < 16; t++) ws[t] = msg[t];
        for (int t = 16; t < 64; t++)
            ws[t] = m_s1(ws[t-2]) + ws[t-7] + m_s0(ws[t-15]) + ws[t-16];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_abc();
        for (int j = 0; j < 16; j++) msg[j] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        model();
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        word_valid = 1'b1;
        word_i     = w;
        n = 0;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) chk("word_ready_timeout", {63'd0, word_ready}, 64'd1);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic load_block(input int gapped);
        for (int j = 0; j < 16; j++) begin
            if (j == 15) chk("valid_before_last_word", {63'd0, out_valid}, 64'd0);
            send_word(msg[j]);
            if (gapped != 0 && j < 15) @(negedge clk);
        end
        chk("first_valid_latency", {63'd0, out_valid}, 64'd1);
        chk("ready_low_in_run", {63'd0, word_ready}, 64'd0);
    endtask

    task automatic run_sched(input int stall_at, input int junk, input int b2b,
                             input logic [31:0] nextw, input int full, output int waits);
        int n;
        out_ready = 1'b1;
        waits = 0;
        for (int t = 0; t < 64; t++) begin
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
                waits++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
                return;
            end
            chk("w_t", {26'd0, t_o, w_o}, {26'd0, 6'(t), ws[t]});
            cap_w[t] = w_o;
            cap_k[t] = k_o;
            if (t == 63) cap_last63 = last_o;
            if (full != 0) begin
                chk("k_t", {32'd0, k_o}, {32'd0, KT[t]});
                chk("last_t", {63'd0, last_o}, {63'd0, (t == 63)});
            end
            if (stall_at == t) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_hold", {25'd0, out_valid, t_o, w_o}, {25'd0, 1'b1, 6'(t), ws[t]});
                    chk("stall_k", {32'd0, k_o}, {32'd0, KT[t]});
                end
                out_ready = 1'b1;
            end
            if (junk != 0) begin
                word_valid = (t < 63);
                word_i     = 32'hdeadbeef ^ 32'(t);
                if (t % 16 == 0) chk("ready_low_junk", {63'd0, word_ready}, 64'd0);
            end
            if (b2b != 0 && t == 63) begin
                word_valid = 1'b1;
                word_i     = nextw;
                chk("b2b_ready_low_at_63", {63'd0, word_ready}, 64'd0);
            end
            @(negedge clk);
        end
        chk("end_valid_low", {62'd0, out_valid, last_o}, 64'd0);
        chk("end_ready_high", {63'd0, word_ready}, 64'd1);
    endtask

    initial begin
        int waits;
        rst_n      = 1'b1;
        word_i     = 32'h0;
        word_valid = 1'b0;
        out_ready  = 1'b0;
        cap_last63 = 1'b0;

        // power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_t_o", {58'd0, t_o}, 64'd0);
        chk("reset_w_o", {32'd0, w_o}, 64'd0);
        chk("reset_last_o", {63'd0, last_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_word_ready", {63'd0, word_ready}, 64'd1);
        @(negedge clk);

        // "abc" block, no backpressure
        set_abc();
        load_block(0);
        run_sched(-1, 0, 0, 32'h0, 1, waits);
        chk("abc_consecutive", 64'(waits), 64'd0);
        chk("abc_W0", {32'd0, cap_w[0]}, {32'd0, 32'h61626380});
        chk("abc_K0", {32'd0, cap_k[0]}, {32'd0, 32'h428a2f98});
        chk("abc_W16", {32'd0, cap_w[16]}, {32'd0, 32'h61626380});
        chk("abc_W17", {32'd0, cap_w[17]}, {32'd0, 32'h000f0000});
        chk("abc_K63", {32'd0, cap_k[63]}, {32'd0, 32'hc67178f2});
        chk("abc_last63", {63'd0, cap_last63}, 64'd1);

        // backpressure at t = 17
        set_abc();
        load_block(0);
        run_sched(17, 0, 0, 32'h0, 1, waits);
        chk("bp_W17", {32'd0, cap_w[17]}, {32'd0, 32'h000f0000});

        // gapped load, junk offered during RUN
        for (int j = 0; j < 16; j++) msg[j] = $urandom;
        model();
        load_block(1);
        run_sched(-1, 1, 0, 32'h0, 1, waits);
        word_valid = 1'b0;

        // back-to-back blocks
        for (int j = 0; j < 16; j++) begin
            msg[j]  = $urandom;
            msgb[j] = $urandom;
        end
        model();
        load_block(0);
        run_sched(-1, 0, 1, msgb[0], 1, waits);
        for (int j = 0; j < 16; j++) msg[j] = msgb[j];
        model();
        load_block(0);
        run_sched(-1, 0, 0, 32'h0, 1, waits);
        chk("b2b_second_K0", {32'd0, cap_k[0]}, {32'd0, 32'h428a2f98});

        // reset in the middle of a schedule
        set_abc();
        load_block(0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("pre_reset_t20", {58'd0, t_o}, 64'd20);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_t_o", {58'd0, t_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_word_ready", {63'd0, word_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        for (int j = 0; j < 16; j++) msg[j] = $urandom;
        model();
        load_block(0);
        run_sched(-1, 0, 0, 32'h0, 1, waits);

        // random blocks
        for (int b = 0; b < 100; b++) begin
            for (int j = 0; j < 16; j++) msg[j] = $urandom;
            model();
            load_block(0);
            run_sched(-1, 0, 0, 32'h0, 0, waits);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
